i2s_sample_tx: RTL and testbench



---
 rtl/i2s_sample_tx.sv | 141 ++++++++++++++
 tb/tb_i2s_sample_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_tx.sv
// Philips I2S transmitter on mclk = 256 x fs: one-deep holding buffer, frame shadow, underrun flag.
// Optional: define I2S_TX_UNDERRUN_MUTE_EN to play a silent frame on underrun instead of repeating.
module i2s_sample_tx #(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic signed [SAMPLE_BITS-1:0] s_left,
  input  logic signed [SAMPLE_BITS-1:0] s_right,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          underrun_clr,
  output logic                          underrun,
  output logic                          frame_start,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata
);

  localparam int MPB_LOG2 = (SLOT_BITS == 64) ? 1 : 2;
  localparam int K_W      = $clog2(SLOT_BITS);

  logic [7:0]             r_cnt;
  logic [SAMPLE_BITS-1:0] r_hold_l;
  logic [SAMPLE_BITS-1:0] r_hold_r;
  logic                   r_hold_full;
  logic [SAMPLE_BITS-1:0] r_shadow_l;
  logic [SAMPLE_BITS-1:0] r_shadow_r;
  logic                   r_s_ready;
  logic                   r_underrun;
  logic                   r_frame_start;
  logic                   r_bclk;
  logic                   r_lrclk;
  logic                   r_sdata;

  logic [7:0]             w_cnt_nxt;
  logic                   w_load;
  logic                   w_xfer;
  logic [SAMPLE_BITS-1:0] w_hold_l_nxt;
  logic [SAMPLE_BITS-1:0] w_hold_r_nxt;
  logic                   w_hold_full_nxt;
  logic [SAMPLE_BITS-1:0] w_shadow_l_nxt;
  logic [SAMPLE_BITS-1:0] w_shadow_r_nxt;
  logic                   w_underrun_nxt;
  logic [K_W-1:0]         w_k;
  logic [SAMPLE_BITS-1:0] w_sample;
  logic                   w_sdata_nxt;

  assign w_cnt_nxt = r_cnt + 8'd1;
  assign w_load    = (r_cnt == 8'hFF);
  assign w_xfer    = s_valid && r_s_ready;

  // Buffer / shadow / flag next-state.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    w_hold_l_nxt    = r_hold_l;
    w_hold_r_nxt    = r_hold_r;
    w_hold_full_nxt = r_hold_full;
    w_shadow_l_nxt  = r_shadow_l;
    w_shadow_r_nxt  = r_shadow_r;
    w_underrun_nxt  = r_underrun && !underrun_clr;

    if (w_load) begin
      if (r_hold_full) begin
        w_shadow_l_nxt  = r_hold_l;
        w_shadow_r_nxt  = r_hold_r;
        w_hold_full_nxt = 1'b0;
      end else if (s_valid) begin
        // Bypass: the pair arriving exactly at the load goes straight into the shadow.
        w_shadow_l_nxt = s_left;
        w_shadow_r_nxt = s_right;
      end else begin
        w_underrun_nxt = 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
        w_shadow_l_nxt = '0;
        w_shadow_r_nxt = '0;
`else
        w_shadow_l_nxt = r_shadow_l;
        w_shadow_r_nxt = r_shadow_r;
`endif
      end
    end else if (w_xfer) begin
      w_hold_l_nxt    = s_left;
      w_hold_r_nxt    = s_right;
      w_hold_full_nxt = 1'b1;
    end
  end

  // Serial formatting is computed from the next counter value so the flops match cnt with zero latency.
  assign w_k      = w_cnt_nxt[MPB_LOG2 +: K_W];
  assign w_sample = w_cnt_nxt[7] ? w_shadow_r_nxt : w_shadow_l_nxt;

  always_comb begin
    w_sdata_nxt = 1'b0;
    for (int i = 0; i < SAMPLE_BITS; i++) begin
      if (w_k == K_W'(SAMPLE_BITS - i)) w_sdata_nxt = w_sample[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_hold_full   <= 1'b0;
      r_shadow_l    <= '0;
      r_shadow_r    <= '0;
      r_s_ready     <= 1'b0;
      r_underrun    <= 1'b0;
      r_frame_start <= 1'b0;
      r_bclk        <= 1'b0;
      r_lrclk       <= 1'b0;
      r_sdata       <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_hold_full   <= w_hold_full_nxt;
      r_shadow_l    <= w_shadow_l_nxt;
      r_shadow_r    <= w_shadow_r_nxt;
      r_s_ready     <= !w_hold_full_nxt;
      r_underrun    <= w_underrun_nxt;
      r_frame_start <= w_load;
      r_bclk        <= w_cnt_nxt[MPB_LOG2-1];
      r_lrclk       <= w_cnt_nxt[7];
      r_sdata       <= w_sdata_nxt;
    end
  end

  // NOTE: holding-buffer data is left unreset; it is only ever read while r_hold_full marks it valid.
  always_ff @(posedge mclk) begin
    r_hold_l <= w_hold_l_nxt;
    r_hold_r <= w_hold_r_nxt;
  end

  assign s_ready     = r_s_ready;
  assign underrun    = r_underrun;
  assign frame_start = r_frame_start;
  assign i2s_bclk    = r_bclk;
  assign i2s_lrclk   = r_lrclk;
  assign i2s_sdata   = r_sdata;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Self-checking bench for i2s_sample_tx: frame-level reference model plus directed literal checks.
module tb_i2s_sample_tx;

  localparam int SB    = 16;
  localparam int SLOTB = 32;
  localparam int MPB   = 128 / SLOTB;

  typedef struct {
    logic [SB-1:0] l;
    logic [SB-1:0] r;
  } pair_t;

  logic                 mclk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [SB-1:0] s_left = '0;
  logic signed [SB-1:0] s_right = '0;
  logic                 s_valid = 1'b0;
  logic                 underrun_clr = 1'b0;
  logic                 s_ready;
  logic                 underrun;
  logic                 frame_start;
  logic                 i2s_bclk;
  logic                 i2s_lrclk;
  logic                 i2s_sdata;

  int checks = 0;
  int errors = 0;

  i2s_sample_tx #(.SAMPLE_BITS(SB), .SLOT_BITS(SLOTB)) dut (
    .mclk        (mclk),
    .rst         (rst),
    .s_left      (s_left),
    .s_right     (s_right),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .underrun_clr(underrun_clr),
    .underrun    (underrun),
    .frame_start (frame_start),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which pair is playing, what is queued, and where in the frame we are.
  bit    m_en = 1'b0;
  bit    m_rst = 1'b1;
  int    m_cnt = 0;
  pair_t m_cur = '{l: '0, r: '0};
  pair_t m_pend[$];
  bit    m_under = 1'b0;
  bit    m_fs = 1'b0;

  always @(negedge mclk) begin
    logic [5:0]    exp_v;
    logic [5:0]    act_v;
    logic [SB-1:0] smp;
    logic [SB-1:0] tmp;
    logic          sd;
    logic          rdy;
    bit            nxt_under;
    int            k;
    pair_t         p;

    rdy = !m_rst && (m_pend.size() == 0);
    if (m_en) begin
      if (m_rst) begin
        exp_v = '0;
      end else begin
        k   = (m_cnt / MPB) % SLOTB;
        smp = (m_cnt >= 128) ? m_cur.r : m_cur.l;
        sd  = 1'b0;
        if (k >= 1 && k <= SB) begin
          tmp = smp >> (SB - k);
          sd  = tmp[0];
        end
        exp_v = {rdy, m_under, m_fs, ((m_cnt % MPB) >= MPB / 2), (m_cnt >= 128), sd};
      end
      act_v = {s_ready, underrun, frame_start, i2s_bclk, i2s_lrclk, i2s_sdata};
      check("cycle_outputs", act_v, exp_v);
    end

    if (rst) begin
      m_rst   = 1'b1;
      m_cnt   = 0;
      m_cur   = '{l: '0, r: '0};
      m_pend.delete();
      m_under = 1'b0;
      m_fs    = 1'b0;
      m_en    = 1'b1;
    end else begin
      nxt_under = m_under && !underrun_clr;
      if (m_cnt == 255) begin
        if (m_pend.size() != 0) begin
          m_cur = m_pend.pop_front();
        end else if (s_valid) begin
          m_cur = '{l: s_left, r: s_right};
        end else begin
          nxt_under = 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
          m_cur = '{l: '0, r: '0};
`endif
        end
        m_fs = 1'b1;
      end else begin
        if (s_valid && rdy) begin
          p = '{l: s_left, r: s_right};
          m_pend.push_back(p);
        end
        m_fs = 1'b0;
      end
      m_under = nxt_under;
      m_cnt   = (m_cnt + 1) % 256;
      m_rst   = 1'b0;
    end
  end

  task automatic wait_frame_start();
    logic found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge mclk);
      found = frame_start;
    end
    check("frame_start_seen", found, 1);
  endtask

  task automatic send_pair(input logic [SB-1:0] l, input logic [SB-1:0] r);
    logic acc = 1'b0;
    @(posedge mclk);
    #1;
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    for (int i = 0; i < 600 && !acc; i++) begin
      @(posedge mclk);
      acc = s_ready;
    end
    #1 s_valid = 1'b0;
    check("pair_accepted", acc, 1);
  endtask

  // Called at the negedge of a frame_start cycle; returns at the negedge of that frame's last cycle.
  task automatic capture_frame(output logic [63:0] wl, output logic [63:0] wr);
    int slot;
    wl = '0;
    wr = '0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge mclk);
      if (i % MPB == 0) begin
        slot = i / MPB;
        if (slot < SLOTB) wl[SLOTB-1-slot] = i2s_sdata;
        else              wr[2*SLOTB-1-slot] = i2s_sdata;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic          acc;
    logic [63:0]   wl;
    logic [63:0]   wr;
    logic [63:0]   exp_l;
    logic [63:0]   exp_r;
    logic [SB-1:0] bp_l;
    logic [SB-1:0] bp_r;
    int            xfers;

    // Reset and release
    repeat (4) @(posedge mclk);
    @(negedge mclk);
    check("ready_in_reset", s_ready, 0);
    @(posedge mclk);
    #1 rst = 1'b0;
    @(posedge mclk);
    @(negedge mclk);
    check("ready_after_release", s_ready, 1);
    wait_frame_start();
    check("first_load_underrun", underrun, 1);

    // Known pair, then one frame of captured serial data
    send_pair(16'h8001, 16'h7FFE);
    underrun_clr = 1'b1;
    @(posedge mclk);
    #1 underrun_clr = 1'b0;
    wait_frame_start();
    capture_frame(wl, wr);
    check("left_word", wl, 64'h4000_8000);
    check("right_word", wr, 64'h3FFF_0000);
    check("no_underrun_after_pair", underrun, 0);

    // Continuous valid: one transfer per frame
    @(posedge mclk);
    #1;
    s_valid = 1'b1;
    s_left  = SB'($urandom);
    s_right = SB'($urandom);
    wait_frame_start();
    xfers = 0;
    for (int i = 0; i < 4 * 256; i++) begin
      @(posedge mclk);
      acc = s_ready;
      #1;
      if (acc) begin
        xfers++;
        s_left  = SB'($urandom);
        s_right = SB'($urandom);
      end
    end
    s_valid = 1'b0;
    check("one_xfer_per_frame", xfers, 4);

    // Bypass: valid first raised in the load cycle with the buffer empty
    wait_frame_start();
    repeat (255) @(posedge mclk);
    #1;
    bp_l    = SB'($urandom);
    bp_r    = SB'($urandom);
    s_left  = bp_l;
    s_right = bp_r;
    s_valid = 1'b1;
    @(posedge mclk);
    #1 s_valid = 1'b0;
    @(negedge mclk);
    check("bypass_frame_start", frame_start, 1);
    check("bypass_ready_cnt0", s_ready, 1);
    @(negedge mclk);
    check("bypass_ready_cnt1", s_ready, 1);

    // Underrun, clear, then clear coinciding with the next underrun
    wait_frame_start();
    check("underrun_set", underrun, 1);
    @(posedge mclk);
    #1 underrun_clr = 1'b1;
    @(posedge mclk);
    #1 underrun_clr = 1'b0;
    @(negedge mclk);
    check("underrun_cleared", underrun, 0);
    repeat (253) @(posedge mclk);
    #1 underrun_clr = 1'b1;
    @(posedge mclk);
    #1 underrun_clr = 1'b0;
    @(negedge mclk);
    check("set_wins_over_clr", underrun, 1);
    check("fs_on_underrun", frame_start, 1);
    capture_frame(wl, wr);
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    exp_l = '0;
    exp_r = '0;
`else
    exp_l = 64'(bp_l) << (SLOTB - 1 - SB);
    exp_r = 64'(bp_r) << (SLOTB - 1 - SB);
`endif
    check("underrun_frame_left", wl, exp_l);
    check("underrun_frame_right", wr, exp_r);

    // Reset in the middle of the right channel
    send_pair(SB'($urandom), SB'($urandom));
    wait_frame_start();
    repeat (140) @(posedge mclk);
    #1 rst = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    check("reset_outputs_zero",
          {s_ready, underrun, frame_start, i2s_bclk, i2s_lrclk, i2s_sdata}, 0);
    @(posedge mclk);
    #1 rst = 1'b0;
    @(posedge mclk);
    @(negedge mclk);
    check("ready_after_midframe_reset", s_ready, 1);
    wait_frame_start();
    check("underrun_after_reset", underrun, 1);
    capture_frame(wl, wr);
    check("post_reset_left_zero", wl, 0);
    check("post_reset_right_zero", wr, 0);

    // Randomized traffic and flag clears
    for (int i = 0; i < 3000; i++) begin
      @(posedge mclk);
      acc = s_valid && s_ready;
      #1;
      if (acc) s_valid = 1'b0;
      if (!s_valid && $urandom_range(0, 179) == 0) begin
        s_left  = SB'($urandom);
        s_right = SB'($urandom);
        s_valid = 1'b1;
      end
      underrun_clr = ($urandom_range(0, 63) == 0);
    end
    underrun_clr = 1'b0;
    s_valid      = 1'b0;
    repeat (4) @(posedge mclk);
    @(negedge mclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
